run_pattern_gen: RTL and testbench

RUN_PATTERN_GEN -- requirements
Module: run_pattern_gen

---
 rtl/run_pattern_gen.sv | 77 +++++++
 tb/tb_run_pattern_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/run_pattern_gen.sv
// Serial run generator: emits req_bit for req_len cycles per accepted request and
// predicts a downstream run detector that fires after DET_LEN equal consecutive bits.
module run_pattern_gen #(
    parameter int LEN_W   = 4,
    parameter int DET_LEN = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             req_valid,
    input  logic             req_bit,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic             err,
    output logic             expect_det
);
    localparam int CNT_W = $clog2(DET_LEN + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             out_n, err_n, accept;

    // rem counts the output cycles left in the run, including the current one
    assign done       = (state == SEND) && (rem == LEN_W'(1));
    assign req_ready  = (state == IDLE) || done;
    assign out_valid  = (state == SEND);
    assign expect_det = (cnt >= CNT_W'(DET_LEN));
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_n = state;
        rem_n   = rem;
        out_n   = out;
        err_n   = 1'b0;
        if (state == SEND && !done) begin
            rem_n = rem - LEN_W'(1);
        end else begin
            if (state == SEND)
                state_n = IDLE;
            if (accept) begin
                if (req_len != '0) begin
                    state_n = SEND;
                    rem_n   = req_len;
                    out_n   = req_bit;
                end else begin
                    err_n = 1'b1;
                end
            end
        end
        // a zero count means no cycle since reset has been counted yet
        if (out_n == out && cnt != '0)
            cnt_n = (cnt == CNT_W'(DET_LEN)) ? cnt : cnt + CNT_W'(1);
        else
            cnt_n = CNT_W'(1);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            rem   <= '0;
            out   <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            out   <= out_n;
            err   <= err_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_run_pattern_gen.sv
// Bench for run_pattern_gen: directed vector table, reset/idle sequences, and a
// randomized run against a queue-based reference model.
module tb_run_pattern_gen;
    localparam int LEN_W   = 4;
    localparam int DET_LEN = 4;

    logic             clk = 1'b0;
    logic             RESET = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_bit = 1'b0;
    logic [LEN_W-1:0] req_len = '0;
    logic             req_ready, out, out_valid, done, err, expect_det;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_pattern_gen #(.LEN_W(LEN_W), .DET_LEN(DET_LEN)) dut (
        .clk(clk), .RESET(RESET), .req_valid(req_valid), .req_bit(req_bit),
        .req_len(req_len), .req_ready(req_ready), .out(out), .out_valid(out_valid),
        .done(done), .err(err), .expect_det(expect_det)
    );

    // observed vector: {out, out_valid, done, err, expect_det, req_ready}
    function automatic logic [5:0] obs();
        return {out, out_valid, done, err, expect_det, req_ready};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got={out,vld,done,err,det,rdy}=%b want=%b", name, act, exp);
        end
    endtask

    typedef struct {
        logic             v;
        logic             b;
        logic [LEN_W-1:0] len;
        logic [5:0]       exp;
    } vec_t;

    vec_t vecs[19];

    // reference model: pend holds bits still to be emitted after the current cycle
    bit pend[$];
    bit hist[$];
    bit m_out, m_valid, m_err;

    task automatic model_reset();
        pend.delete();
        hist.delete();
        m_out = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input int len);
        bit acc;
        acc   = v && (pend.size() == 0);
        m_err = acc && (len == 0);
        if (acc) repeat (len) pend.push_back(b);
        if (pend.size() > 0) begin
            m_out   = pend.pop_front();
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        hist.push_back(m_out);
        if (hist.size() > DET_LEN) void'(hist.pop_front());
    endtask

    function automatic logic [5:0] model_exp();
        int run;
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            run++;
        end
        return {m_out, m_valid, m_valid && (pend.size() == 0), m_err,
                run >= DET_LEN, pend.size() == 0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] seq38 [4];
        bit   accepted;

        vecs[0]  = '{1'b1, 1'b1, 4'd5, 6'b110000};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 6'b110000};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 6'b110000};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 6'b110010};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 6'b111011};
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 6'b100011};
        vecs[6]  = '{1'b1, 1'b0, 4'd2, 6'b010000};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 6'b011001};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 6'b000001};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 6'b000011};
        vecs[10] = '{1'b1, 1'b1, 4'd2, 6'b110000};
        vecs[11] = '{1'b1, 1'b1, 4'd3, 6'b111001};
        vecs[12] = '{1'b1, 1'b1, 4'd3, 6'b110000};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 6'b110010};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 6'b111011};
        vecs[15] = '{1'b1, 1'b0, 4'd0, 6'b100111};
        vecs[16] = '{1'b0, 1'b0, 4'd0, 6'b100011};
        vecs[17] = '{1'b1, 1'b0, 4'd0, 6'b100111};
        vecs[18] = '{1'b0, 1'b0, 4'd0, 6'b100011};

        seq38[0] = 6'b010000;
        seq38[1] = 6'b011001;
        seq38[2] = 6'b000001;
        seq38[3] = 6'b000011;

        #1 RESET = 1'b1;
        #1 chk("reset_state", obs(), 6'b000001);

        // directed table: single run, value change, back-to-back, zero-length
        @(negedge clk);
        RESET = 1'b0;
        for (int i = 0; i < 19; i++) begin
            req_valid = vecs[i].v;
            req_bit   = vecs[i].b;
            req_len   = vecs[i].len;
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end
        req_valid = 1'b0;

        // idle hold from a zero counter
        do_reset();
        RESET = 1'b0;
        req_valid = 1'b1; req_bit = 1'b0; req_len = 4'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("idle_hold%0d", i), obs(), seq38[i]);
        end

        // reset mid-run
        do_reset();
        RESET = 1'b0;
        req_valid = 1'b1; req_bit = 1'b1; req_len = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrun_pre", obs(), 6'b110000);
        @(posedge clk);
        #2 RESET = 1'b1;
        #1 chk("midrun_reset", obs(), 6'b000001);
        @(negedge clk);
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("midrun_nodone%0d", i), {4'b0, done, out_valid}, 6'b0);
        end

        // randomized run against the reference model
        do_reset();
        RESET = 1'b0;
        model_reset();
        accepted = 1;
        for (int c = 0; c < 3000; c++) begin
            if (accepted || !req_valid) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_bit   = ($urandom_range(0, 2) != 0) ? m_out : ~m_out;
                req_len   = ($urandom_range(0, 9) == 0) ? 4'd0 :
                            ($urandom_range(0, 4) == 0) ? LEN_W'($urandom_range(1, 15))
                                                        : LEN_W'($urandom_range(1, 4));
            end
            accepted = req_valid && (pend.size() == 0);
            @(posedge clk);
            model_step(req_valid, req_bit, int'(req_len));
            @(negedge clk);
            chk($sformatf("rand%0d", c), obs(), model_exp());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
